// File: rtl/uart_pack_assembler.sv
// Assembles PACK_NUM received UART bytes into output pattern, freq pattern and
// control byte; publishes with a 1-cycle strobe and drops stale partial packs.
module uart_pack_assembler #(
  parameter int DATA_BIT       = 32,
  parameter int PACK_NUM       = 9,
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int CNT_W          = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [7:0]          i_data,
  input  logic                i_rx_done_tick,
  output logic [DATA_BIT-1:0] o_output_pattern,
  output logic [DATA_BIT-1:0] o_freq_pattern,
  output logic [7:0]          o_ctrl,
  output logic                o_pack_valid,
  output logic                o_busy,
  output logic                o_timeout_tick,
  output logic [CNT_W-1:0]    o_byte_cnt
);
  localparam int NB = DATA_BIT / 8;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0]    T_LAST   = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PACK_NUM - 1);

  typedef enum logic [1:0] {IDLE, COLLECT, PUBLISH} state_t;

  state_t                   state;
  logic [PACK_NUM-1:0][7:0] shadow;
  logic [CNT_W-1:0]         cnt;
  logic [TW-1:0]            timer;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= IDLE;
      shadow           <= '0;
      cnt              <= '0;
      timer            <= '0;
      o_output_pattern <= '0;
      o_freq_pattern   <= '0;
      o_ctrl           <= '0;
      o_pack_valid     <= 1'b0;
      o_timeout_tick   <= 1'b0;
    end else begin
      o_pack_valid   <= 1'b0;
      o_timeout_tick <= 1'b0;
      case (state)
        IDLE: begin
          if (i_rx_done_tick) begin
            shadow[0] <= i_data;
            cnt       <= CNT_W'(1);
            timer     <= '0;
            state     <= COLLECT;
          end
        end
        COLLECT: begin
          // a byte arriving on the last timer cycle still beats the timeout
          if (i_rx_done_tick) begin
            shadow[cnt] <= i_data;
            cnt         <= cnt + 1'b1;
            timer       <= '0;
            if (cnt == CNT_LAST) state <= PUBLISH;
          end else if (timer == T_LAST) begin
            o_timeout_tick <= 1'b1;
            cnt            <= '0;
            timer          <= '0;
            state          <= IDLE;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        PUBLISH: begin
          o_pack_valid     <= 1'b1;
          o_output_pattern <= shadow[NB-1:0];
          o_freq_pattern   <= shadow[2*NB-1:NB];
          o_ctrl           <= shadow[2*NB];
          // a tick here is byte 0 of the next pack; the copy above uses the old shadow
          if (i_rx_done_tick) begin
            shadow[0] <= i_data;
            cnt       <= CNT_W'(1);
            timer     <= '0;
            state     <= COLLECT;
          end else begin
            cnt   <= '0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign o_busy     = (state == COLLECT);
  assign o_byte_cnt = cnt;
endmodule

// File: tb/tb_uart_pack_assembler.sv
// Scoreboard bench: a 32-bit instance (short timeout) and a 16-bit instance.
module tb_uart_pack_assembler;
  localparam int TO_A = 64;
  localparam int TO_B = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [31:0] op;
    logic [31:0] fp;
    logic [7:0]  ctrl;
    int          cyc;
  } exp_t;

  // ---------------- instance A ----------------
  logic        rst_a, tick_a;
  logic [7:0]  data_a;
  logic [31:0] op_a, fp_a;
  logic [7:0]  ctrl_a;
  logic        valid_a, busy_a, to_a;
  logic [3:0]  cnt_a;

  uart_pack_assembler #(.DATA_BIT(32), .PACK_NUM(9), .TIMEOUT_CYCLES(TO_A), .CNT_W(4)) dut_a (
    .clk(clk), .rst(rst_a), .i_data(data_a), .i_rx_done_tick(tick_a),
    .o_output_pattern(op_a), .o_freq_pattern(fp_a), .o_ctrl(ctrl_a),
    .o_pack_valid(valid_a), .o_busy(busy_a), .o_timeout_tick(to_a), .o_byte_cnt(cnt_a)
  );

  // ---------------- instance B ----------------
  logic        rst_b, tick_b;
  logic [7:0]  data_b;
  logic [15:0] op_b, fp_b;
  logic [7:0]  ctrl_b;
  logic        valid_b, busy_b, to_b;
  logic [2:0]  cnt_b;

  uart_pack_assembler #(.DATA_BIT(16), .PACK_NUM(5), .TIMEOUT_CYCLES(TO_B), .CNT_W(3)) dut_b (
    .clk(clk), .rst(rst_b), .i_data(data_b), .i_rx_done_tick(tick_b),
    .o_output_pattern(op_b), .o_freq_pattern(fp_b), .o_ctrl(ctrl_b),
    .o_pack_valid(valid_b), .o_busy(busy_b), .o_timeout_tick(to_b), .o_byte_cnt(cnt_b)
  );

  // ---------------- model / scoreboard ----------------
  exp_t       q_a[$], q_b[$];
  logic [7:0] bq_a[$], bq_b[$];
  exp_t       last_a, last_b;
  int         nv_a = 0, nv_b = 0, nto_a = 0, nto_b = 0;

  function automatic exp_t build(input logic [7:0] bq[$], input int nb, input int c);
    exp_t e;
    e.op = '0; e.fp = '0;
    for (int i = 0; i < nb; i++) begin
      e.op[8*i +: 8] = bq[i];
      e.fp[8*i +: 8] = bq[nb+i];
    end
    e.ctrl = bq[2*nb];
    e.cyc  = c;
    return e;
  endfunction

  // drive one byte in the current cycle; returns one cycle later (#1 after the edge)
  task automatic put_a(input logic [7:0] b);
    data_a = b; tick_a = 1'b1;
    bq_a.push_back(b);
    if (bq_a.size() == 9) begin
      q_a.push_back(build(bq_a, 4, cyc + 2));
      bq_a.delete();
    end
    @(posedge clk); #1;
    tick_a = 1'b0; data_a = $urandom;
  endtask

  task automatic put_b(input logic [7:0] b);
    data_b = b; tick_b = 1'b1;
    bq_b.push_back(b);
    if (bq_b.size() == 5) begin
      q_b.push_back(build(bq_b, 2, cyc + 2));
      bq_b.delete();
    end
    @(posedge clk); #1;
    tick_b = 1'b0; data_b = $urandom;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (!rst_a && to_a) nto_a++;
    if (!rst_b && to_b) nto_b++;
    if (!rst_a && valid_a) begin
      nv_a++;
      if (q_a.size() == 0) chk("a_unexpected_valid", 64'd1, 64'd0);
      else begin
        exp_t e;
        e = q_a.pop_front();
        chk("a_op", 64'(op_a), 64'(e.op));
        chk("a_fp", 64'(fp_a), 64'(e.fp));
        chk("a_ctrl", 64'(ctrl_a), 64'(e.ctrl));
        chk("a_latency", 64'(cyc), 64'(e.cyc));
        last_a = e;
      end
    end
    if (!rst_b && valid_b) begin
      nv_b++;
      if (q_b.size() == 0) chk("b_unexpected_valid", 64'd1, 64'd0);
      else begin
        exp_t e;
        e = q_b.pop_front();
        chk("b_op", 64'(op_b), 64'(e.op));
        chk("b_fp", 64'(fp_b), 64'(e.fp));
        chk("b_ctrl", 64'(ctrl_b), 64'(e.ctrl));
        chk("b_latency", 64'(cyc), 64'(e.cyc));
        last_b = e;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int v0, t0;
    logic [7:0] t1 [9];
    t1 = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h05};
    last_a = '{op: 0, fp: 0, ctrl: 0, cyc: 0};
    last_b = last_a;
    rst_a = 1'b1; rst_b = 1'b1;
    tick_a = 1'b0; tick_b = 1'b0; data_a = 8'h00; data_b = 8'h00;
    idle(3);
    // reset state
    chk("rst_op", 64'(op_a), 64'd0);
    chk("rst_ctrl", 64'(ctrl_a), 64'd0);
    chk("rst_valid", 64'(valid_a), 64'd0);
    chk("rst_busy", 64'(busy_a), 64'd0);
    chk("rst_cnt", 64'(cnt_a), 64'd0);
    rst_a = 1'b0; rst_b = 1'b0;
    idle(2);

    // T1: spaced bytes, fixed values
    v0 = nv_a;
    for (int i = 0; i < 9; i++) begin
      put_a(t1[i]);
      if (i < 8) idle(9);
    end
    idle(4);
    chk("t1_op", 64'(op_a), 64'h12345678);
    chk("t1_fp", 64'(fp_a), 64'hDEADBEEF);
    chk("t1_ctrl", 64'(ctrl_a), 64'h05);
    chk("t1_pulses", 64'(nv_a - v0), 64'd1);

    // T2: partial pack, timeout, then full pack
    for (int i = 0; i < 4; i++) put_a(8'hA0 + 8'(i));
    chk("t2_cnt4", 64'(cnt_a), 64'd4);
    chk("t2_busy", 64'(busy_a), 64'd1);
    t0 = nto_a;
    idle(TO_A + 5);
    bq_a.delete();
    chk("t2_timeouts", 64'(nto_a - t0), 64'd1);
    chk("t2_busy0", 64'(busy_a), 64'd0);
    chk("t2_cnt0", 64'(cnt_a), 64'd0);
    chk("t2_hold_op", 64'(op_a), 64'h12345678);
    chk("t2_hold_ctrl", 64'(ctrl_a), 64'h05);
    for (int i = 0; i < 9; i++) put_a(8'($urandom));
    idle(4);

    // T3: 18 back-to-back bytes, byte 9 lands in the publish cycle
    v0 = nv_a;
    for (int i = 0; i < 18; i++) put_a(8'($urandom));
    idle(4);
    chk("t3_pulses", 64'(nv_a - v0), 64'd2);

    // T4: tick on the last timer cycle beats the timeout
    t0 = nto_a;
    put_a(8'h11);
    idle(TO_A - 1);
    put_a(8'h22);
    chk("t4_cnt2", 64'(cnt_a), 64'd2);
    chk("t4_busy", 64'(busy_a), 64'd1);
    for (int i = 0; i < 7; i++) put_a(8'h30 + 8'(i));
    idle(4);
    chk("t4_no_timeout", 64'(nto_a - t0), 64'd0);

    // T5: reset mid-pack clears everything immediately
    for (int i = 0; i < 6; i++) put_a(8'($urandom));
    v0 = nv_a; t0 = nto_a;
    rst_a = 1'b1; #1;
    chk("t5_op0", 64'(op_a), 64'd0);
    chk("t5_fp0", 64'(fp_a), 64'd0);
    chk("t5_cnt0", 64'(cnt_a), 64'd0);
    chk("t5_busy0", 64'(busy_a), 64'd0);
    bq_a.delete();
    idle(2);
    rst_a = 1'b0;
    idle(TO_A + 2);
    chk("t5_no_events", 64'((nv_a - v0) + (nto_a - t0)), 64'd0);
    for (int i = 0; i < 9; i++) put_a(8'($urandom));
    idle(4);

    // T6: small instance
    for (int i = 0; i < 5; i++) put_b(8'hC0 + 8'(i));
    idle(4);
    chk("t6_op", 64'(op_b), 64'hC1C0);
    chk("t6_fp", 64'(fp_b), 64'hC3C2);
    chk("t6_ctrl", 64'(ctrl_b), 64'hC4);
    t0 = nto_b;
    put_b(8'h01); put_b(8'h02);
    idle(TO_B + 2);
    bq_b.delete();
    chk("t6_timeout", 64'(nto_b - t0), 64'd1);
    chk("t6_cnt0", 64'(cnt_b), 64'd0);
    chk("t6_hold_op", 64'(op_b), 64'hC1C0);
    for (int i = 0; i < 5; i++) put_b(8'($urandom));
    idle(4);

    chk("a_queue_empty", 64'(q_a.size()), 64'd0);
    chk("b_queue_empty", 64'(q_b.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
